// File: rtl/pipeline_control_pkg.sv
// rtl/pipeline_control_pkg.sv - shared types and defaults for the pipeline stall/flush controller
//
// Purpose : FSM state encoding of the flush controller and the PC width
//           shared with the fetch unit.
// Ports   : none (package).
package pipeline_control_pkg;

    localparam int PC_ADDR_WIDTH = 32;

    typedef enum logic {
        PC_IDLE  = 1'b0,
        PC_FLUSH = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pipeline_control_if.sv
// rtl/pipeline_control_if.sv - stall/flush request and control bundle of the pipeline controller
//
// Purpose : groups the per-stage stall requests, exception/redirect events
//           and the resulting stall/flush/restart-PC controls.
// Ports   : master - pipeline side (drives requests, consumes controls)
//           slave  - pipeline_control side (consumes requests, drives controls)
interface pipeline_control_if
    import pipeline_control_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int ADDR_WIDTH = PC_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 32
);

    logic [NUM_STAGES-1:0] stall_req;
    logic                  exc_valid;
    logic [ADDR_WIDTH-1:0] exc_pc;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [NUM_STAGES-1:0] stall;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_pc;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  stall_count;

    modport master (
        output stall_req, exc_valid, exc_pc, redirect_valid, redirect_pc,
        input  stall, flush, flush_pc, busy, stall_count
    );

    modport slave (
        input  stall_req, exc_valid, exc_pc, redirect_valid, redirect_pc,
        output stall, flush, flush_pc, busy, stall_count
    );

endinterface

// File: rtl/pipeline_control_stall_backprop.sv
// rtl/pipeline_control_stall_backprop.sv - suffix-OR stall back-propagation with flush mask
//
// Purpose : a stall request from stage j stalls stages 0..j; all stalls are
//           suppressed while a flush is in progress.
// Ports   : i_stall_req - per-stage stall requests (level)
//           i_flush     - flush active, masks every stall
//           o_stall     - per-stage stall to the pipeline registers
module pipeline_control_stall_backprop #(
    parameter int NUM_STAGES = 5
) (
    input  logic [NUM_STAGES-1:0] i_stall_req,
    input  logic                  i_flush,
    output logic [NUM_STAGES-1:0] o_stall
);

    logic w_acc;

    // Walk from the last stage towards fetch, accumulating the OR of all
    // requests at or after the current stage.
    always_comb begin
        o_stall = '0;
        w_acc   = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            w_acc      = w_acc | i_stall_req[i];
            o_stall[i] = w_acc & ~i_flush;
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - central stall/flush generator for the in-order pipeline
//
// Purpose : back-propagates per-stage stalls, registers exception/redirect
//           flushes (held FLUSH_CYCLES cycles, exception beats redirect) and
//           counts cycles in which fetch is stalled (saturating).
// Ports   : i_clk   - clock, all state on posedge
//           i_rst_n - asynchronous active-low reset
//           bus     - pipeline_control_if.slave: stall_req, exc_valid/exc_pc,
//                     redirect_valid/redirect_pc in; stall, flush, flush_pc,
//                     busy, stall_count out
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int ADDR_WIDTH   = PC_ADDR_WIDTH,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    pipeline_control_if.slave  bus
);

    // Counter only needs to hold FLUSH_CYCLES-1; keep at least one bit.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    pc_state_e             r_state;
    pc_state_e             w_state_nxt;
    logic [FC_W-1:0]       r_flush_cnt;
    logic [FC_W-1:0]       w_flush_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_flush_pc;
    logic [ADDR_WIDTH-1:0] w_flush_pc_nxt;
    logic [CNT_WIDTH-1:0]  r_stall_count;
    logic [NUM_STAGES-1:0] w_stall;
    logic                  w_flush;

    assign w_flush = (r_state == PC_FLUSH);

    pipeline_control_stall_backprop #(
        .NUM_STAGES (NUM_STAGES)
    ) u_stall_backprop (
        .i_stall_req (bus.stall_req),
        .i_flush     (w_flush),
        .o_stall     (w_stall)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= PC_IDLE;
            r_flush_cnt <= '0;
            r_flush_pc  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_flush_pc  <= w_flush_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_flush_pc_nxt  = r_flush_pc;
        case (r_state)
            PC_IDLE: begin
                // Exception checked first: a same-cycle redirect is dropped.
                if (bus.exc_valid) begin
                    w_state_nxt     = PC_FLUSH;
                    w_flush_cnt_nxt = FC_LOAD;
                    w_flush_pc_nxt  = bus.exc_pc;
                end else if (bus.redirect_valid) begin
                    w_state_nxt     = PC_FLUSH;
                    w_flush_cnt_nxt = FC_LOAD;
                    w_flush_pc_nxt  = bus.redirect_pc;
                end
            end
            PC_FLUSH: begin
                // Redirects are ignored here; a younger exception restarts
                // the whole window with its own handler PC.
                if (bus.exc_valid) begin
                    w_flush_cnt_nxt = FC_LOAD;
                    w_flush_pc_nxt  = bus.exc_pc;
                end else if (r_flush_cnt == '0) begin
                    w_state_nxt = PC_IDLE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
                end
            end
            default: begin
                w_state_nxt = PC_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall[0] && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_WIDTH'(1);
        end
    end

    assign bus.stall       = w_stall;
    assign bus.flush       = w_flush;
    assign bus.busy        = w_flush;
    assign bus.flush_pc    = r_flush_pc;
    assign bus.stall_count = r_stall_count;

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central stall/flush generator for the in-order front/back pipeline. It collects per-stage stall requests and exception/redirect events, and drives the `stall`, `flush` and restart-PC signals that every per-stage pipeline register consumes. A stall in stage i is back-propagated to all earlier stages. Flushes are registered, held for a configurable number of cycles, and arbitrated so that exceptions beat branch redirects. A saturating stall-cycle counter is exported for performance monitoring.

## Interface
- `NUM_STAGES`, 5: pipeline stages; index 0 is fetch, `NUM_STAGES-1` is the last stage.
- `ADDR_WIDTH`, 32: PC width.
- `FLUSH_CYCLES`, 1: cycles `flush` stays high per event; ≥1.
- `CNT_WIDTH`, 32: stall counter width.

Ports:
- `clk`  in  1  single clock; all state on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall_req`  in  NUM_STAGES  per-stage stall request, level.
- `exc_valid`  in  1  exception commit, one-cycle pulse.
- `exc_pc`  in  ADDR_WIDTH  handler PC, valid with `exc_valid`.
- `redirect_valid`  in  1  branch mispredict redirect, pulse.
- `redirect_pc`  in  ADDR_WIDTH  target PC, valid with `redirect_valid`.
- `stall`  out  NUM_STAGES  per-stage stall to pipeline registers.
- `flush`  out  1  flush all pipeline registers.
- `flush_pc`  out  ADDR_WIDTH  restart PC, valid while `flush`.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `stall_count`  out  CNT_WIDTH  cycles with `stall[0]` high, saturating.

## Operation
- Stall vector, combinational: `stall[i] = |stall_req[NUM_STAGES-1:i]`. A request from stage j stalls stages 0..j. Later stages keep running, so the pipeline register after stage j inserts bubbles.
- While `flush` is high, `stall` is forced to all zeros. Flush takes priority over stalls.
- FSM states:
  - IDLE: `flush` = 0.
    - `exc_valid` → load `flush_pc` = `exc_pc`, counter = FLUSH_CYCLES-1, go to FLUSH.
    - Otherwise `redirect_valid` → same, using `redirect_pc`.
    - If both are high the same cycle, the exception wins and the redirect is dropped.
  - FLUSH: `flush` = 1, `busy` = 1.
    - `exc_valid` → reload `flush_pc` = `exc_pc` and restart the counter at FLUSH_CYCLES-1.
    - `redirect_valid` is ignored.
    - Counter = 0 with no new exception → IDLE.
    - Otherwise decrement the counter.
- `stall_count` increments by 1 each cycle in which `stall[0]` is 1 (after masking). It holds at all-ones once it saturates.
- Reset values:
  - `flush` = 0, `flush_pc` = 0, `busy` = 0, `stall_count` = 0, FSM = IDLE.
  - `stall` follows `stall_req` immediately after reset, because `flush` = 0.
- Reset asserted mid-flush aborts the flush asynchronously. There is no pending-event memory.

## Timing
- `stall`: zero latency from `stall_req` (same cycle), except while masked by `flush`.
- Flush: event sampled at edge t → `flush` and `flush_pc` are high from just after edge t through FLUSH_CYCLES cycles. They drop after edge t+FLUSH_CYCLES unless an exception restarts the flush.
- `busy` equals `flush` in the current FSM, and is registered.
- `stall_count` is registered: it reflects stalls up to the previous cycle.
- `flush_pc` is stable for the whole flush window unless an exception restarts it.

## Structure
- Shared package holds:
  - the FSM state encoding (`PC_IDLE`, `PC_FLUSH`);
  - the `ADDR_WIDTH` default, shared with the fetch unit.
- One sub-module is natural: `stall_backprop`, the combinational suffix-OR over `stall_req` plus the flush mask, parameterised by `NUM_STAGES`.
- The FSM, counters and PC register stay in the top.

## Test plan
1. Reset release with `stall_req` = 5'b00100: `stall` = 5'b00111, `flush` = 0, `stall_count` increments every cycle.
2. `redirect_valid` pulse with `redirect_pc` = 0x8000_0040, FLUSH_CYCLES = 2:
   - `flush` high for exactly 2 cycles starting the next cycle, with `flush_pc` = 0x8000_0040;
   - `stall` = 0 during that window even with `stall_req` = 5'b11111.
3. `exc_valid` (pc 0xBFC0_0380) and `redirect_valid` (pc 0x1000) in the same cycle: `flush_pc` = 0xBFC0_0380.
4. Exception during the second cycle of a 3-cycle redirect flush: `flush_pc` switches to the exception PC and `flush` lasts 3 more cycles. A redirect during the flush leaves `flush_pc` unchanged.
5. Async `rst` low mid-flush, between clock edges: `flush`, `busy`, `flush_pc` and `stall_count` go to 0 immediately.
6. CNT_WIDTH = 4 with `stall_req[0]` held for 20 cycles: `stall_count` saturates at 15 and holds.
